// File: rtl/proc_pkg.sv
// Shared processor-slice definitions: default datapath width and a
// constant-foldable ceil(log2) used to size index fields.
package proc_pkg;

    localparam int WORD_W = 16;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int unsigned n);
        int          r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux16_arbiter.sv
// Combinational rotating-priority arbiter. Picks the first requester at or
// above ptr, wrapping to 0; the pointer itself is held by the parent.
module rr_arbiter
    import proc_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  gidx,
    output logic              any
);

    // Two-pass search: channels ptr..NUM_IN-1 first, then 0..ptr-1.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (en && !any && req[i] && (SEL_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                gidx     = SEL_W'(i);
                any      = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (en && !any && req[i] && (SEL_W'(i) < ptr)) begin
                grant[i] = 1'b1;
                gidx     = SEL_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux16.sv
// Registered N:1 merge point with valid/ready on every input and on the
// output. Round-robin or fixed-select arbitration, one word per cycle.
module rr_mux16
    import proc_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (NUM_IN > 1) ? clog2(NUM_IN) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_IN-1:0]         IN_VALID,
    input  logic [NUM_IN*WIDTH-1:0]   IN_DATA,
    output logic [NUM_IN-1:0]         IN_READY,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          S,
    output logic [WIDTH-1:0]          O,
    output logic                      O_VALID,
    input  logic                      O_READY,
    output logic [SEL_W-1:0]          O_SRC
);

    logic              load;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  gidx;
    logic              any;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_next;
    logic [WIDTH-1:0]  sel_data;

    // Output register accepts when empty or being drained this cycle.
    assign load = !O_VALID || O_READY;

    // Eligibility mask: every valid channel, or only channel S in fixed mode.
    // An out-of-range S matches no channel, so nothing is eligible.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            req[i] = IN_VALID[i] && (!MODE || (S == SEL_W'(i)));
        end
    end

    // Fixed select reuses the rotating search: with a single request bit the
    // pointer position cannot change which channel wins.
    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .en    (load),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // Grant is already gated by load, so it is exactly the consume strobe.
    assign IN_READY = grant;

    // One-hot data select of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advances past the winner, wrapping at NUM_IN-1.
    always_comb begin
        ptr_next = '0;
        if (gidx != SEL_W'(NUM_IN - 1)) begin
            ptr_next = gidx + 1'b1;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O       <= '0;
            O_VALID <= 1'b0;
            O_SRC   <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (any) begin
                O       <= sel_data;
                O_SRC   <= gidx;
                O_VALID <= 1'b1;
                ptr     <= ptr_next;
            end else begin
                O_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux16.md
# rr_mux16

Parametrised, registered N-input multiplexer with a valid/ready handshake on every input and on the output. It chooses among requesting sources either round-robin or by a fixed select. It generalises the combinational 16-bit 4:1 datapath mux into a flow-controlled merge point, such as memory-port or writeback-bus sharing between processor units. It has one output register stage, so a new word can be accepted every cycle.

## Interface
- `WIDTH`, default 16: data width of each input and of the output.
- `NUM_IN`, default 4: number of input channels, at least 1.
- `SEL_W`, default max(1, clog2(NUM_IN)): width of `S` and `O_SRC`. Derived; never overridden.

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `IN_VALID`  in  NUM_IN  channel i offers a word.
- `IN_DATA`  in  NUM_IN*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- `IN_READY`  out  NUM_IN  channel i word is consumed this cycle.
- `MODE`  in  1  0 = round-robin, 1 = fixed select.
- `S`  in  SEL_W  selected channel when MODE=1.
- `O`  out  WIDTH  registered output data.
- `O_VALID`  out  1  `O` holds an unconsumed word.
- `O_READY`  in  1  downstream accepts `O` this cycle.
- `O_SRC`  out  SEL_W  index of the channel that supplied `O`.

## Operation
- Transfer rule: a transfer occurs on any edge where VALID and READY are both high, on an input or on the output.
- `load` = !O_VALID | O_READY. The output register can take a new word when it is empty or is being drained.
- Eligible channels:
  - MODE=0: every channel with `IN_VALID[i]`.
  - MODE=1: only channel `S`, and only if `IN_VALID[S]`.
  - If `S` >= NUM_IN, no channel is eligible.
- Grant:
  - MODE=0: the first eligible channel searching upward from `ptr`, wrapping from NUM_IN-1 to 0.
  - MODE=1: channel `S`.
  - At most one grant is active per cycle.
- `IN_READY[i]` = grant[i] & load. This is combinational from `IN_VALID`, `MODE`, `S`, `O_READY` and state.
- On an input transfer:
  - `O` takes `IN_DATA[g]`.
  - `O_SRC` takes g.
  - `O_VALID` is set to 1.
  - `ptr` takes (g+1) mod NUM_IN. This applies in both modes.
- If `load` is high and there is no grant, `O_VALID` is set to 0. `O` and `O_SRC` keep their previous values.
- If `load` is low, `O`, `O_SRC` and `O_VALID` hold. `IN_READY` is all zero.
- State is the output register, `O_VALID`, `O_SRC`, and the round-robin pointer `ptr` (SEL_W bits). There is no other FSM.

## Timing
- Reset values: `O`=0, `O_VALID`=0, `O_SRC`=0, `ptr`=0. `IN_READY` follows combinationally; during reset it reflects `load`=1.
- Latency: an input accepted at edge k appears on `O` with `O_VALID`=1 after edge k.
- Throughput: one word per cycle when `O_READY` is held high.
- Backpressure: while `O_VALID`=1 and `O_READY`=0, `O`/`O_SRC` are stable and no input is consumed.
- Simultaneous drain and refill in one cycle is allowed. `O_VALID` stays 1 and data changes.
- `MODE` or `S` changes take effect at the next arbitration. An already-registered word is unaffected.
- Reset mid-stream: the registered word is discarded, with no output transfer. `ptr` returns to 0.
- NUM_IN=1: behaves as a 1-deep pipeline register. `ptr` stays 0.
- Fairness: with all inputs valid and `O_READY`=1, the grant order is 0,1,…,NUM_IN-1 repeating.

## Structure
- Shared package `proc_pkg` holds `clog2` and the default `WORD_W`=16.
- Sub-module `rr_arbiter`:
  - Parameters: NUM_IN.
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `grant`, encoded `gidx`, `any`.
  - Purely combinational. `ptr` and all registers live in `rr_mux16`.

## Test plan
- After reset, `O`=0, `O_VALID`=0, `O_SRC`=0. Then channel 0 valid with data 'hA534 and `O_READY`=1: next cycle `O`='hA534, `O_SRC`=0.
- MODE=0, all 4 valid ('hA534,'hDAFD,'hDFDF,'hAAAA), `O_READY`=1 for 8 cycles: `O` cycles through all four words in order, twice, with `O_SRC` 0,1,2,3,0,1,2,3.
- MODE=1, S=2, all valid: only `IN_READY[2]` pulses, and `O`='hDFDF every cycle. S=3 with `IN_VALID[3]`=0: `O_VALID` drops after one cycle.
- `O_READY`=0 for 5 cycles with `O`='hDAFD held: `O` and `O_SRC` are stable and `IN_READY`=0. Raise `O_READY`: the next grant comes from channel 2, following the pointer.
- Assert `RST` asynchronously between edges while `O_VALID`=1: outputs clear immediately, no transfer is counted, and the first grant after release comes from channel 0.
- Re-run the round-robin scenario with WIDTH=8, NUM_IN=3, and with NUM_IN=1: order and latency hold.
